// File: rtl/rf_wb_scoreboard.sv
// Write-back arbiter and hazard scoreboard for the 8 x 16-bit register file.
// The ALU and load unit share one registered write port; issue stalls on RAW/WAW.
module rf_wb_scoreboard #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic            iss_use_a,
  input  logic            iss_use_b,
  input  logic [AW-1:0]   iss_ra,
  input  logic [AW-1:0]   iss_rb,
  input  logic            iss_wr,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            alu_wb_valid,
  input  logic [AW-1:0]   alu_wb_rd,
  input  logic [DW-1:0]   alu_wb_data,
  output logic            alu_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [AW-1:0]   mem_wb_rd,
  input  logic [DW-1:0]   mem_wb_data,
  output logic            mem_wb_ready,
  output logic            WE_R,
  output logic [AW-1:0]   WrReg_Rd,
  output logic [DW-1:0]   InData_R,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);

  typedef enum logic {GntAlu, GntMem} grant_e;

  grant_e          last_grant;
  grant_e          last_grant_next;
  logic            hazard;
  logic            issue_fire;
  logic            accept;
  logic [AW-1:0]   acc_rd;
  logic [DW-1:0]   acc_data;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;
  logic [NREG-1:0] busy_next;

  always_comb begin
    hazard     = (iss_use_a & busy[iss_ra]) | (iss_use_b & busy[iss_rb]) |
                 (iss_wr & busy[iss_rd]);
    iss_ready  = ~hazard;
    issue_fire = iss_valid & iss_ready & iss_wr;
  end

  // Round-robin only matters under contention; a lone requester leaves last_grant alone.
  always_comb begin
    alu_wb_ready    = 1'b0;
    mem_wb_ready    = 1'b0;
    last_grant_next = last_grant;
    if (alu_wb_valid && mem_wb_valid) begin
      if (last_grant == GntMem) begin
        alu_wb_ready    = 1'b1;
        last_grant_next = GntAlu;
      end else begin
        mem_wb_ready    = 1'b1;
        last_grant_next = GntMem;
      end
    end else begin
      alu_wb_ready = alu_wb_valid;
      mem_wb_ready = mem_wb_valid;
    end
    accept   = alu_wb_ready | mem_wb_ready;
    acc_rd   = alu_wb_ready ? alu_wb_rd : mem_wb_rd;
    acc_data = alu_wb_ready ? alu_wb_data : mem_wb_data;
  end

  // Clear tracks the registered write so a dependent reads the committed value; set wins.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_set[i] = issue_fire && (iss_rd == AW'(i));
      busy_clr[i] = WE_R && (WrReg_Rd == AW'(i));
    end
    busy_next = (busy & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      WE_R       <= 1'b0;
      WrReg_Rd   <= '0;
      InData_R   <= '0;
      wb_err     <= 1'b0;
      last_grant <= GntMem;
    end else begin
      busy       <= busy_next;
      WE_R       <= accept;
      last_grant <= last_grant_next;
      if (accept) begin
        WrReg_Rd <= acc_rd;
        InData_R <= acc_data;
        if (!busy[acc_rd]) wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Write-back controller and hazard scoreboard for the 8 x 16-bit register file. It has a single write port (WE_R / WrReg_Rd / InData_R).
- It arbitrates two write-back requesters onto that one port: the ALU and the load/memory unit.
- It tracks pending destination registers and stalls issue on RAW/WAW hazards.
- It sits between the issue stage, the execute/memory units and the register file.

Parameters:
- NREG, 8, number of architectural registers.
- AW, 3, register index width (log2 NREG).
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  issue stage presents an instruction.
- iss_use_a  in  1  instruction reads iss_ra.
- iss_use_b  in  1  instruction reads iss_rb.
- iss_ra  in  AW  source A register.
- iss_rb  in  AW  source B register.
- iss_wr  in  1  instruction writes iss_rd.
- iss_rd  in  AW  destination register.
- iss_ready  out  1  no hazard; issue fires when iss_valid & iss_ready.
- alu_wb_valid  in  1  ALU result pending.
- alu_wb_rd  in  AW  ALU destination.
- alu_wb_data  in  DW  ALU result.
- alu_wb_ready  out  1  ALU result accepted this cycle.
- mem_wb_valid  in  1  load result pending.
- mem_wb_rd  in  AW  load destination.
- mem_wb_data  in  DW  load result.
- mem_wb_ready  out  1  load result accepted this cycle.
- WE_R  out  1  register file write enable (registered).
- WrReg_Rd  out  AW  register file write index (registered).
- InData_R  out  DW  register file write data (registered).
- busy  out  NREG  scoreboard: bit i = write to Ri outstanding.
- wb_err  out  1  sticky: write-back arrived for a non-busy register.

Behaviour:
- Reset (async, immediate): busy=0, WE_R=0, WrReg_Rd=0, InData_R=0, wb_err=0, last_grant=MEM (so ALU wins first contest).
- Hazard (combinational): (iss_use_a & busy[iss_ra]) | (iss_use_b & busy[iss_rb]) | (iss_wr & busy[iss_rd]).
- iss_ready = ~hazard. iss_ready is independent of iss_valid.
- Issue fire (iss_valid & iss_ready & iss_wr): set busy[iss_rd] at the next edge.
- Arbitration, combinational each cycle:
  - Only one valid: that requester is granted.
  - Both valid: grant the one not equal to last_grant (round-robin); last_grant updates to the winner.
  - ready is asserted only for the granted requester. The loser holds its request; requesters must keep rd/data stable while valid & ~ready.
- Accept at cycle N: at edge ending N, WE_R<=1, WrReg_Rd<=rd, InData_R<=data.
- No accept in a cycle: WE_R<=0 at that edge; WrReg_Rd and InData_R hold their last values.
- Latency: accept in cycle N -> WE_R high in cycle N+1 -> regfile written at edge ending N+1.
- busy[WrReg_Rd] clears at the edge ending N+1, i.e. the same edge that writes the regfile. busy is low from N+2.
- Consequence: a dependent instruction issues in N+2 at earliest and reads the committed value. No bypassing.
- The same-edge set and clear of one busy bit cannot occur legally (issue stalls while the bit is set). If it does occur, set wins.
- A write-back accepted while busy[rd]==0 sets wb_err=1 (sticky until reset). The write is still performed.
- Back-to-back accepts every cycle are legal; the write port sustains 1 write/cycle.
- Reset asserted mid-operation: pending writes are dropped, busy cleared, WE_R=0 immediately. Requesters are expected to be reset concurrently.

Test Plan:
- Reset then idle: busy=8'h00, WE_R=0, iss_ready=1, wb_err=0 while reset high and after release.
- Issue wr R3 at cycle 1 -> busy=8'h08 from cycle 2. ALU wb R3=16'h1234 valid cycle 3 -> alu_wb_ready=1 cycle 3; WE_R=1, WrReg_Rd=3, InData_R=16'h1234 in cycle 4; busy=8'h00 from cycle 5.
- RAW stall: R5 busy, issue with use_a, ra=5 -> iss_ready=0 until the cycle after WE_R for R5, then 1. WAW: iss_wr, rd=5 stalls identically.
- Contention: R1 and R2 busy; ALU (R1, 16'h00AA) and MEM (R2, 16'h00BB) both valid cycle 1 -> ALU granted cycle 1, MEM cycle 2. WE_R writes R1 then R2 in consecutive cycles; next contention grants MEM first.
- Spurious write-back: MEM wb R6 with busy[6]=0 -> write performed (WE_R=1, WrReg_Rd=6), wb_err=1 and stays 1.
- Reset mid-op: busy=8'h0C, ALU accepted this cycle, assert reset before the edge -> WE_R stays 0, busy=0, no register write.
